autotest_sweeper: RTL and testbench

- Parametrised successor to the single-shot SD-SPI autotest controller.
- Sequences the UUT through a runtime-programmed grid of (n_blocks, sclk_speed, cmd18) combinations, with a per-point repeat count.
- For each run it resets the UUT, starts it, measures cycles to uut_finish with a timeout, and emits one result record on a valid/ready port; the downstream SD logger consumes that port.

---
 rtl/autotest_sweeper.sv | 209 ++++++++++++++++++++
 tb/tb_autotest_sweeper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/autotest_sweeper.sv
// Sweeps the UUT over an (n_blocks, sclk_speed, cmd18, repeat) grid, timing each run to uut_finish.
// One record per run; rec_valid holds with stable fields until rec_ready, stalling the sweep.
module autotest_sweeper #(
    parameter int N_BLOCK_SIZE    = 32,
    parameter int SCLK_SPEED_SIZE = 4,
    parameter int CMD18_SIZE      = 1,
    parameter int CYCLE_CNT_W     = 32,
    parameter int REPEAT_W        = 4,
    parameter int RST_HOLD        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [N_BLOCK_SIZE-1:0]    nb_first,
    input  logic [N_BLOCK_SIZE-1:0]    nb_last,
    input  logic [N_BLOCK_SIZE-1:0]    nb_step,
    input  logic [SCLK_SPEED_SIZE-1:0] sp_first,
    input  logic [SCLK_SPEED_SIZE-1:0] sp_last,
    input  logic [CMD18_SIZE-1:0]      c18_first,
    input  logic [CMD18_SIZE-1:0]      c18_last,
    input  logic [REPEAT_W-1:0]        repeats,
    input  logic [CYCLE_CNT_W-1:0]     timeout,
    output logic                       uut_ctrl_mux,
    output logic                       uut_rst,
    output logic                       uut_start,
    output logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
    output logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
    output logic [CMD18_SIZE-1:0]      uut_cmd18,
    input  logic                       uut_finish,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [N_BLOCK_SIZE-1:0]    rec_n_blocks,
    output logic [SCLK_SPEED_SIZE-1:0] rec_sclk_speed,
    output logic [CMD18_SIZE-1:0]      rec_cmd18,
    output logic [REPEAT_W-1:0]        rec_iter,
    output logic [CYCLE_CNT_W-1:0]     rec_cycles,
    output logic                       rec_timeout,
    output logic                       busy,
    output logic                       done
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, URST, USTART, RUN, REPORT, NEXT, FIN} state_t;

    state_t                     state;
    logic [N_BLOCK_SIZE-1:0]    nb_first_q, nb_last_q, nb_step_q;
    logic [SCLK_SPEED_SIZE-1:0] sp_first_q, sp_last_q;
    logic [CMD18_SIZE-1:0]      c18_first_q, c18_last_q;
    logic [REPEAT_W-1:0]        rep_q, iter;
    logic [CYCLE_CNT_W-1:0]     timeout_q, cyc_cnt;
    logic [HOLD_W-1:0]          hold_cnt;

    logic [REPEAT_W:0]          iter_inc, rep_eff;
    logic [N_BLOCK_SIZE:0]      nb_sum;
    logic [CYCLE_CNT_W-1:0]     cyc_next;
    logic                       iter_wrap, nb_wrap, sp_wrap, c18_wrap, to_hit;

    // nb sum carries one extra bit so a range ending at all-ones terminates instead of wrapping
    always_comb begin
        iter_inc  = {1'b0, iter} + (REPEAT_W+1)'(1);
        rep_eff   = (rep_q == '0) ? (REPEAT_W+1)'(1) : {1'b0, rep_q};
        iter_wrap = (iter_inc >= rep_eff);
        nb_sum    = {1'b0, uut_n_blocks} + {1'b0, nb_step_q};
        nb_wrap   = (nb_step_q == '0) || (nb_sum > {1'b0, nb_last_q});
        sp_wrap   = (uut_sclk_speed >= sp_last_q);
        c18_wrap  = (uut_cmd18 >= c18_last_q);
        cyc_next  = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYCLE_CNT_W'(1);
        to_hit    = (timeout_q != '0) && (cyc_next == timeout_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            nb_first_q     <= '0;
            nb_last_q      <= '0;
            nb_step_q      <= '0;
            sp_first_q     <= '0;
            sp_last_q      <= '0;
            c18_first_q    <= '0;
            c18_last_q     <= '0;
            rep_q          <= '0;
            timeout_q      <= '0;
            iter           <= '0;
            cyc_cnt        <= '0;
            hold_cnt       <= '0;
            uut_ctrl_mux   <= 1'b0;
            uut_rst        <= 1'b0;
            uut_start      <= 1'b0;
            uut_n_blocks   <= '0;
            uut_sclk_speed <= '0;
            uut_cmd18      <= '0;
            rec_valid      <= 1'b0;
            rec_n_blocks   <= '0;
            rec_sclk_speed <= '0;
            rec_cmd18      <= '0;
            rec_iter       <= '0;
            rec_cycles     <= '0;
            rec_timeout    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (abort && state != IDLE) begin
            state          <= IDLE;
            iter           <= '0;
            cyc_cnt        <= '0;
            hold_cnt       <= '0;
            uut_ctrl_mux   <= 1'b0;
            uut_rst        <= 1'b0;
            uut_start      <= 1'b0;
            uut_n_blocks   <= '0;
            uut_sclk_speed <= '0;
            uut_cmd18      <= '0;
            rec_valid      <= 1'b0;
            rec_n_blocks   <= '0;
            rec_sclk_speed <= '0;
            rec_cmd18      <= '0;
            rec_iter       <= '0;
            rec_cycles     <= '0;
            rec_timeout    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    nb_first_q     <= nb_first;
                    nb_last_q      <= nb_last;
                    nb_step_q      <= nb_step;
                    sp_first_q     <= sp_first;
                    sp_last_q      <= sp_last;
                    c18_first_q    <= c18_first;
                    c18_last_q     <= c18_last;
                    rep_q          <= repeats;
                    timeout_q      <= timeout;
                    uut_n_blocks   <= nb_first;
                    uut_sclk_speed <= sp_first;
                    uut_cmd18      <= c18_first;
                    iter           <= '0;
                    busy           <= 1'b1;
                    uut_ctrl_mux   <= 1'b1;
                    uut_rst        <= 1'b1;
                    hold_cnt       <= '0;
                    state          <= URST;
                end
                URST: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD-1)) begin
                        uut_rst   <= 1'b0;
                        uut_start <= 1'b1;
                        state     <= USTART;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                USTART: begin
                    uut_start <= 1'b0;
                    cyc_cnt   <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (uut_finish || to_hit) begin
                        rec_cycles     <= uut_finish ? cyc_next : timeout_q;
                        rec_timeout    <= ~uut_finish;
                        rec_valid      <= 1'b1;
                        rec_n_blocks   <= uut_n_blocks;
                        rec_sclk_speed <= uut_sclk_speed;
                        rec_cmd18      <= uut_cmd18;
                        rec_iter       <= iter;
                        state          <= REPORT;
                    end else begin
                        cyc_cnt <= cyc_next;
                    end
                end
                REPORT: begin
                    if (rec_ready) begin
                        rec_valid <= 1'b0;
                        state     <= NEXT;
                    end
                end
                NEXT: begin
                    iter <= iter_wrap ? '0 : iter_inc[REPEAT_W-1:0];
                    if (iter_wrap)
                        uut_n_blocks <= nb_wrap ? nb_first_q : nb_sum[N_BLOCK_SIZE-1:0];
                    if (iter_wrap && nb_wrap)
                        uut_sclk_speed <= sp_wrap ? sp_first_q : uut_sclk_speed + SCLK_SPEED_SIZE'(1);
                    if (iter_wrap && nb_wrap && sp_wrap)
                        uut_cmd18 <= c18_wrap ? c18_first_q : uut_cmd18 + CMD18_SIZE'(1);
                    if (iter_wrap && nb_wrap && sp_wrap && c18_wrap) begin
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        uut_ctrl_mux <= 1'b0;
                        state        <= FIN;
                    end else begin
                        uut_rst  <= 1'b1;
                        hold_cnt <= '0;
                        state    <= URST;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_autotest_sweeper.sv
// Directed bench for autotest_sweeper: a behavioural UUT finishes a set number of cycles after start.
module tb_autotest_sweeper;
    localparam int NB = 32, SPW = 4, C18W = 1, CW = 32, RW = 4, RH = 16;

    logic            clk = 1'b0;
    logic            rst, start, abort;
    logic [NB-1:0]   nb_first, nb_last, nb_step;
    logic [SPW-1:0]  sp_first, sp_last;
    logic [C18W-1:0] c18_first, c18_last;
    logic [RW-1:0]   repeats;
    logic [CW-1:0]   timeout;
    logic            uut_ctrl_mux, uut_rst, uut_start, uut_finish;
    logic [NB-1:0]   uut_n_blocks, rec_n_blocks;
    logic [SPW-1:0]  uut_sclk_speed, rec_sclk_speed;
    logic [C18W-1:0] uut_cmd18, rec_cmd18;
    logic            rec_valid, rec_ready, rec_timeout, busy, done;
    logic [RW-1:0]   rec_iter;
    logic [CW-1:0]   rec_cycles;

    typedef struct packed {
        logic [NB-1:0]   nb;
        logic [SPW-1:0]  sp;
        logic [C18W-1:0] c18;
        logic [RW-1:0]   iter;
        logic [CW-1:0]   cyc;
        logic            to;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   checks = 0, errors = 0;
    int   done_cnt = 0, rst_len = 0, rst_run = 0, fin_after = 0, ucnt = 0;
    bit   armed = 0;

    autotest_sweeper #(
        .N_BLOCK_SIZE(NB), .SCLK_SPEED_SIZE(SPW), .CMD18_SIZE(C18W),
        .CYCLE_CNT_W(CW), .REPEAT_W(RW), .RST_HOLD(RH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .nb_first(nb_first), .nb_last(nb_last), .nb_step(nb_step),
        .sp_first(sp_first), .sp_last(sp_last),
        .c18_first(c18_first), .c18_last(c18_last),
        .repeats(repeats), .timeout(timeout),
        .uut_ctrl_mux(uut_ctrl_mux), .uut_rst(uut_rst), .uut_start(uut_start),
        .uut_n_blocks(uut_n_blocks), .uut_sclk_speed(uut_sclk_speed), .uut_cmd18(uut_cmd18),
        .uut_finish(uut_finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_n_blocks(rec_n_blocks), .rec_sclk_speed(rec_sclk_speed), .rec_cmd18(rec_cmd18),
        .rec_iter(rec_iter), .rec_cycles(rec_cycles), .rec_timeout(rec_timeout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // UUT model: finish rises fin_after RUN-cycles after start; 0 means it never finishes
    always @(negedge clk) begin
        if (uut_rst) begin
            armed = 0;
            rst_run++;
        end else begin
            if (rst_run != 0) rst_len = rst_run;
            rst_run = 0;
        end
        if (uut_start) begin
            armed = 1;
            ucnt  = 0;
        end else if (armed) begin
            ucnt++;
        end
        uut_finish = armed && fin_after != 0 && ucnt >= fin_after;
        if (rec_valid && rec_ready)
            got_q.push_back({rec_n_blocks, rec_sclk_speed, rec_cmd18, rec_iter, rec_cycles, rec_timeout});
        if (done) done_cnt++;
    end

    task automatic push_exp(input logic [NB-1:0] nb, input logic [SPW-1:0] sp, input logic [C18W-1:0] c,
                            input logic [RW-1:0] it, input logic [CW-1:0] cyc, input logic to);
        exp_q.push_back({nb, sp, c, it, cyc, to});
    endtask

    task automatic configure(input logic [NB-1:0] nf, nl, ns, input logic [SPW-1:0] sf, sl,
                             input logic [C18W-1:0] cf, cl, input logic [RW-1:0] rp,
                             input logic [CW-1:0] to, input int fa);
        nb_first = nf; nb_last = nl; nb_step = ns;
        sp_first = sf; sp_last = sl; c18_first = cf; c18_last = cl;
        repeats = rp; timeout = to; fin_after = fa;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // mode 1: disturb inputs after LOAD; mode 2: pulse start again mid-sweep
    task automatic run_sweep(input string tag, input int mode);
        bit timed_out;
        got_q.delete();
        done_cnt = 0;
        pulse_start();
        if (mode == 1) begin
            repeat (2) @(posedge clk);
            #1 nb_last = 100;
        end else if (mode == 2) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        timed_out = 1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 0;
                break;
            end
        end
        check({tag, "_timeout"}, 80'(timed_out), 80'(0));
        repeat (40) @(negedge clk);
        check({tag, "_count"}, 80'(got_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_rec%0d", tag, i), 80'(got_q[i]), 80'(exp_q[i]));
        check({tag, "_done_cnt"}, 80'(done_cnt), 80'(1));
        exp_q.delete();
    endtask

    task automatic wait_negedge_for(input string tag, input int which);
        bit seen;
        seen = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ((which == 0 && uut_start) || (which == 1 && uut_rst) || (which == 2 && rec_valid)) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_wait"}, 80'(seen), 80'(1));
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b1; uut_finish = 1'b0;
        configure('0, '0, '0, '0, '0, '0, '0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_uut", 80'({uut_ctrl_mux, uut_rst, uut_start, uut_n_blocks, uut_sclk_speed, uut_cmd18}), 80'(0));
        check("reset_rec", 80'({rec_valid, rec_n_blocks, rec_sclk_speed, rec_cmd18, rec_iter, rec_cycles, rec_timeout}), 80'(0));
        check("reset_status", 80'({busy, done}), 80'(0));
        rst = 1'b0;

        // basic nb sweep; nb_last changed after LOAD must be ignored
        configure(1, 4, 1, 7, 7, 0, 0, 1, 0, 10);
        for (int n = 1; n <= 4; n++) push_exp(NB'(n), 7, 0, 0, 10, 0);
        run_sweep("t1", 1);
        check("t1_rst_hold", 80'(rst_len), 80'(RH));
        check("t1_idle", 80'({busy, uut_ctrl_mux}), 80'(0));

        // full grid with repeats: iter fastest, then nb, sp, c18
        configure(8, 20, 8, 2, 3, 0, 1, 2, 0, 3);
        for (int c = 0; c <= 1; c++)
            for (int s = 2; s <= 3; s++)
                for (int n = 8; n <= 16; n += 8)
                    for (int it = 0; it < 2; it++)
                        push_exp(NB'(n), SPW'(s), C18W'(c), RW'(it), 3, 0);
        run_sweep("t2", 0);

        // timeout, then finish on the timeout cycle
        configure(1, 1, 1, 0, 0, 0, 0, 1, 50, 0);
        push_exp(1, 0, 0, 0, 50, 1);
        run_sweep("t3_to", 0);
        configure(1, 1, 1, 0, 0, 0, 0, 1, 50, 50);
        push_exp(1, 0, 0, 0, 50, 0);
        run_sweep("t3_fin", 0);

        // backpressure
        configure(6, 6, 1, 5, 5, 1, 1, 1, 0, 5);
        rec_ready = 1'b0;
        done_cnt = 0;
        pulse_start();
        wait_negedge_for("t4", 2);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rec_valid || rec_n_blocks !== 6 || rec_sclk_speed !== 5 || rec_cmd18 !== 1 ||
                rec_iter !== 0 || rec_cycles !== 5 || rec_timeout !== 0 ||
                uut_n_blocks !== 6 || uut_sclk_speed !== 5 || uut_cmd18 !== 1 || done)
                bad++;
        end
        check("t4_hold", 80'(bad), 80'(0));
        @(posedge clk); #1 rec_ready = 1'b1;
        @(negedge clk); check("t4_xfer_valid", 80'(rec_valid), 80'(1));
        @(negedge clk); check("t4_next", 80'({rec_valid, done}), 80'(0));
        @(negedge clk); check("t4_done", 80'(done), 80'(1));
        repeat (3) @(negedge clk);

        // abort in RUN
        configure(1, 4, 1, 0, 0, 0, 0, 1, 0, 0);
        done_cnt = 0;
        pulse_start();
        wait_negedge_for("t5_run", 0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("t5_abort", 80'({busy, uut_ctrl_mux, uut_rst, uut_start, rec_valid, uut_n_blocks}), 80'(0));
        repeat (30) @(negedge clk);
        check("t5_abort_nodone", 80'(done_cnt), 80'(0));

        // async reset during URST
        pulse_start();
        wait_negedge_for("t5_urst", 1);
        #2 rst = 1'b1;
        #1 check("t5_rst_async", 80'({busy, uut_ctrl_mux, uut_rst}), 80'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_rst_nodone", 80'(done_cnt), 80'(0));
        fin_after = 10;
        for (int n = 1; n <= 4; n++) push_exp(NB'(n), 0, 0, 0, 10, 0);
        run_sweep("t5_restart", 0);

        // edge ranges
        configure(5, 9, 0, 0, 0, 0, 0, 1, 0, 4);
        push_exp(5, 0, 0, 0, 4, 0);
        run_sweep("t6_step0", 0);
        configure(5, 3, 1, 0, 0, 0, 0, 1, 0, 4);
        push_exp(5, 0, 0, 0, 4, 0);
        run_sweep("t6_rev", 0);
        configure(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 4);
        push_exp(32'h7FFF_FFFF, 0, 0, 0, 4, 0);
        push_exp(32'hFFFF_FFFF, 0, 0, 0, 4, 0);
        run_sweep("t6_top", 0);
        configure(2, 2, 1, 0, 0, 0, 0, 0, 0, 5);
        push_exp(2, 0, 0, 0, 5, 0);
        run_sweep("t6_rep0_restart", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
